mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single unified memory port between FETCH (instruction reads) and MEMORY (loads/stores).
// - One transaction in flight at a time.
// - Drives the memory-side request, routes the response back to the owning stage and produces MEM_STALL for the pipeline.
// - Sits in top between fetch/memory stages and the external memory.
// PARAMETERS
// - ADDR_W        64  address width
// - DATA_W        64  memory data width
// - STARVE_LIMIT  4   consecutive data grants before a forced fetch grant (MEM_ARB_STARVE_GUARD_EN only)
// PORTS
// - CLK        in   1       clock, rising edge
// - RESET      in   1       asynchronous, active-high reset
// - IF_REQ     in   1       fetch read request, held until IF_GNT
// - IF_ADDR    in   ADDR_W  fetch address (word aligned)
// - IF_FLUSH   in   1       redirect: discard any in-flight fetch response
// - IF_GNT     out  1       fetch request accepted this cycle
// - IF_RVALID  out  1       1-cycle pulse, IF_RDATA valid
// - IF_RDATA   out  32      instruction word
// - MEM_REQ    in   1       data request, held until MEM_RVALID
// - MEM_WE     in   1       1=store, 0=load
// - MEM_SIZE   in   2       0=B,1=H,2=W,3=D
// - MEM_ADDR   in   ADDR_W  data address
// - MEM_WDATA  in   DATA_W  store data
// - MEM_GNT    out  1       data request accepted this cycle
// - MEM_RVALID out  1       1-cycle pulse: load data valid / store done
// - MEM_RDATA  out  DATA_W  load data
// - MEM_STALL  out  1       MEM_REQ & ~MEM_RVALID (combinational)
// - M_REQ      out  1       memory request, held until M_ACK
// - M_WE       out  1       latched write enable
// - M_SIZE     out  2       latched size
// - M_ADDR     out  ADDR_W  latched address
// - M_WDATA    out  DATA_W  latched store data
// - M_ACK      in   1       memory done; M_RDATA valid same cycle
// - M_RDATA    in   DATA_W  memory read data
// BEHAVIOUR
// - Reset values: state IDLE; all outputs 0 except MEM_STALL, which follows MEM_REQ.
//   Async reset mid-transaction drops M_REQ immediately. Memory must tolerate abandoned requests.
// - FSM IDLE -> BUSY_I | BUSY_D -> RESP -> IDLE.
//   - IDLE: GNT is combinational, at most one per cycle, in IDLE only. Winner's fields latched into M_* at the edge.
//   - BUSY_x: M_REQ=1 until M_ACK. On M_ACK, M_RDATA is registered, then -> RESP.
//   - RESP: owner's RVALID=1 for exactly one cycle, then -> IDLE.
// - Priority: MEM_REQ beats IF_REQ (older instruction first).
// - Min latency: GNT at cycle N, M_REQ at N+1, M_ACK at N+1 earliest, RVALID at N+2, next GNT at N+3.
// - IF_RDATA = latched IF_ADDR[2] ? rdata[63:32] : rdata[31:0].
// - MEM_RDATA = raw 64-bit word. Memory stage does extract/extend.
// - IF_FLUSH handling:
//   - Flush in BUSY_I, or in RESP for a fetch, suppresses IF_RVALID for that transaction; the memory access still completes.
//   - Flush in IDLE on the same cycle as IF_REQ still grants; no response is suppressed.
// - M_ACK outside BUSY_x is ignored.
// - Requests arriving in BUSY/RESP wait; GNT stays 0.
// CONFIGURATION
// - MEM_ARB_STARVE_GUARD_EN defined:
//   - 3-bit counter increments on each MEM_GNT while IF_REQ=1; clears on IF_GNT or when IF_REQ=0.
//   - Counter == STARVE_LIMIT with both requesting: fetch wins.
// - Undefined: strict data priority, no counter.
// TESTING
// - Lone fetch IF_ADDR=0x1004, M_ACK 2 cycles after M_REQ, M_RDATA=0xAAAA_BBBB_CCCC_DDDD -> IF_RVALID 1 cycle, IF_RDATA=0xAAAABBBB.
// - IF_REQ and MEM_REQ (load 0x2000) same IDLE cycle -> MEM_GNT=1, IF_GNT=0; fetch granted first IDLE cycle after MEM_RVALID.
// - Store MEM_ADDR=0x3008 WDATA=0x55 SIZE=3 -> M_WE=1, M_ADDR=0x3008, MEM_STALL=1 until MEM_RVALID pulse, then 0.
// - IF_FLUSH during BUSY_I -> M_REQ held until M_ACK, no IF_RVALID, FSM back to IDLE.
// - RESET asserted in BUSY_D -> M_REQ, MEM_RVALID drop without clock edge; after release, fresh request gets GNT in 1 cycle.
// - Guard on, STARVE_LIMIT=4, both held continuously -> 4 MEM_GNTs then IF_GNT. Guard off -> no IF_GNT while MEM_REQ=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between instruction fetch and the
// data (load/store) stage. Only one transaction is in flight at a time. The
// block drives the memory-side request, steers the response back to the
// stage that owns it and produces MEM_STALL for the pipeline.
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   IF_REQ/IF_ADDR        fetch read request, held until IF_GNT
//   IF_FLUSH              redirect: drop any in-flight fetch response
//   IF_GNT                fetch accepted this cycle (combinational, IDLE only)
//   IF_RVALID/IF_RDATA    one-cycle fetch response, 32-bit instruction word
//   MEM_REQ/WE/SIZE/ADDR/WDATA  data request, held until MEM_RVALID
//   MEM_GNT               data request accepted this cycle (combinational)
//   MEM_RVALID/MEM_RDATA  one-cycle load data / store done, raw 64-bit word
//   MEM_STALL             MEM_REQ & ~MEM_RVALID (combinational)
//   M_REQ/M_WE/M_SIZE/M_ADDR/M_WDATA  memory request, held until M_ACK
//   M_ACK/M_RDATA         memory completion, read data valid with M_ACK
//
// Build option
//   MEM_ARB_STARVE_GUARD_EN  when defined, a fetch that has watched
//                            STARVE_LIMIT consecutive data grants wins the
//                            next arbitration. Undefined: strict data priority.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  // fetch side
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  input  logic              IF_FLUSH,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [31:0]       IF_RDATA,
  // data side
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [1:0]        MEM_SIZE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_GNT,
  output logic              MEM_RVALID,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_STALL,
  // memory side
  output logic              M_REQ,
  output logic              M_WE,
  output logic [1:0]        M_SIZE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic              M_ACK,
  input  logic [DATA_W-1:0] M_RDATA
);

  localparam int unsigned SIZE_W = 2;
  localparam int unsigned HALF_W = 32;
  localparam logic [SIZE_W-1:0] FETCH_SIZE = SIZE_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic                own_data_q, own_data_d;
  logic                flush_q,    flush_d;
  logic                addr2_q,    addr2_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic                m_we_q,     m_we_d;
  logic [SIZE_W-1:0]   m_size_q,   m_size_d;
  logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q,  m_wdata_d;

  logic if_gnt_c;
  logic mem_gnt_c;
  logic if_rvalid_c;
  logic mem_rvalid_c;
  logic fetch_force_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Fetch has watched enough back-to-back data grants: let it go first.
  assign fetch_force_c = (starve_cnt_q == STARVE_LIM) & IF_REQ & MEM_REQ;

  // Count data grants a waiting fetch has lost; any gap in IF_REQ restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!IF_REQ || if_gnt_c) begin
      starve_cnt_d = '0;
    end else if (mem_gnt_c && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict data priority; the limit only matters with the guard built in.
  logic unused_starve_limit;
  assign unused_starve_limit = ^(32'(STARVE_LIMIT));
  assign fetch_force_c = 1'b0;
`endif

  // Arbitration, request latching and transaction sequencing.
  always_comb begin
    state_d      = state_q;
    own_data_d   = own_data_q;
    flush_d      = flush_q;
    addr2_d      = addr2_q;
    rdata_d      = rdata_q;
    m_we_d       = m_we_q;
    m_size_d     = m_size_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    if_gnt_c     = 1'b0;
    mem_gnt_c    = 1'b0;
    if_rvalid_c  = 1'b0;
    mem_rvalid_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while RESET is held so every output reads 0.
        if (!RESET) begin
          if (MEM_REQ && !fetch_force_c) begin
            mem_gnt_c  = 1'b1;
            own_data_d = 1'b1;
            m_we_d     = MEM_WE;
            m_size_d   = MEM_SIZE;
            m_addr_d   = MEM_ADDR;
            m_wdata_d  = MEM_WDATA;
            state_d    = ST_BUSY_D;
          end else if (IF_REQ) begin
            // A flush on the grant cycle belongs to the old stream, not this one.
            if_gnt_c   = 1'b1;
            own_data_d = 1'b0;
            flush_d    = 1'b0;
            addr2_d    = IF_ADDR[2];
            m_we_d     = 1'b0;
            m_size_d   = FETCH_SIZE;
            m_addr_d   = IF_ADDR;
            state_d    = ST_BUSY_I;
          end
        end
      end

      ST_BUSY_I: begin
        if (IF_FLUSH) begin
          flush_d = 1'b1;
        end
        if (M_ACK) begin
          rdata_d = M_RDATA;
          state_d = ST_RESP;
        end
      end

      ST_BUSY_D: begin
        if (M_ACK) begin
          rdata_d = M_RDATA;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // A flush arriving in the response cycle itself still kills the pulse.
        if (own_data_q) begin
          mem_rvalid_c = 1'b1;
        end else begin
          if_rvalid_c = ~flush_q & ~IF_FLUSH;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      own_data_q <= 1'b0;
      flush_q    <= 1'b0;
      addr2_q    <= 1'b0;
      rdata_q    <= '0;
      m_we_q     <= 1'b0;
      m_size_q   <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_data_q <= own_data_d;
      flush_q    <= flush_d;
      addr2_q    <= addr2_d;
      rdata_q    <= rdata_d;
      m_we_q     <= m_we_d;
      m_size_q   <= m_size_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign IF_GNT     = if_gnt_c;
  assign MEM_GNT    = mem_gnt_c;
  assign IF_RVALID  = if_rvalid_c;
  assign MEM_RVALID = mem_rvalid_c;
  assign MEM_STALL  = MEM_REQ & ~mem_rvalid_c;

  // Fetch returns the 32-bit half of the memory word picked by address bit 2.
  assign IF_RDATA   = addr2_q ? rdata_q[HALF_W +: HALF_W] : rdata_q[0 +: HALF_W];
  assign MEM_RDATA  = rdata_q;

  assign M_REQ      = (state_q == ST_BUSY_I) | (state_q == ST_BUSY_D);
  assign M_WE       = m_we_q;
  assign M_SIZE     = m_size_q;
  assign M_ADDR     = m_addr_q;
  assign M_WDATA    = m_wdata_q;

endmodule
